lfsr_prng: RTL and testbench

Parametrised Fibonacci LFSR pseudo-random generator with a selectable tap polynomial. Seeding is parallel or serial, and the block runs in free-run, single-step or counted-burst mode. A fetch/write handshake returns registered output snapshots. It feeds test-pattern and scrambler logic in the lab datapath and is the generalised successor of the fixed 6-bit shift-register generator.

---
 rtl/lfsr_pkg.sv | 24 ++
 rtl/lfsr_core.sv | 76 +++++++
 rtl/lfsr_prng.sv | 146 ++++++++++++++
 tb/tb_lfsr_prng.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the LFSR pseudo-random generator.
// Holds the FSM state enum, the Fibonacci next-state helper and the 6-bit defaults.
package lfsr_pkg;

    localparam int unsigned LFSR_MAX_W = 32;

    localparam logic [5:0] DEF_TAPS_6 = 6'b110000;
    localparam logic [5:0] DEF_SEED_6 = 6'h01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BURST = 2'd2
    } fsm_state_e;

    // Fibonacci step on a zero-extended state; caller truncates to its width.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] taps
    );
        return {state[LFSR_MAX_W-2:0], ^(state & taps)};
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// LFSR state register with parallel/serial seeding, zero guard and advance enable.
// Optional signature compression (data_in/misr_mode) when LFSR_MISR_EN is defined.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int unsigned         WIDTH        = 6,
    parameter logic [WIDTH-1:0]    TAPS         = WIDTH'(DEF_TAPS_6),
    parameter logic [WIDTH-1:0]    DEFAULT_SEED = WIDTH'(DEF_SEED_6)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             seed_load_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic             shift_en_i,
    input  logic             seed_bit_i,
    input  logic             adv_en_i,
`ifdef LFSR_MISR_EN
    input  logic [WIDTH-1:0] data_in_i,
    input  logic             misr_mode_i,
`endif
    output logic [WIDTH-1:0] state_o,
    output logic             lockup_o
);

    logic [WIDTH-1:0] state_q, state_d;
    logic             lockup_q, lockup_d;
    logic [WIDTH-1:0] load_val;
    logic             load_c;
    logic [WIDTH-1:0] adv_val;

    // Load beats shift beats advance; only loads and shifts pass the zero guard.
    always_comb begin
        state_d  = state_q;
        lockup_d = 1'b0;
        load_c   = 1'b0;
        load_val = '0;
        adv_val  = WIDTH'(lfsr_next(LFSR_MAX_W'(state_q), LFSR_MAX_W'(TAPS)));
`ifdef LFSR_MISR_EN
        if (misr_mode_i) begin
            adv_val = adv_val ^ data_in_i;
        end
`endif
        if (seed_load_i) begin
            load_c   = 1'b1;
            load_val = seed_i;
        end else if (shift_en_i) begin
            load_c   = 1'b1;
            load_val = {state_q[WIDTH-2:0], seed_bit_i};
        end

        if (load_c) begin
            if (load_val == '0) begin
                state_d  = DEFAULT_SEED;
                lockup_d = 1'b1;
            end else begin
                state_d = load_val;
            end
        end else if (adv_en_i) begin
            state_d = adv_val;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= DEFAULT_SEED;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lockup_q <= lockup_d;
        end
    end

    assign state_o  = state_q;
    assign lockup_o = lockup_q;

endmodule

// File: rtl/lfsr_prng.sv
// LFSR PRNG top: IDLE/RUN/BURST control, burst counter and fetch snapshot handshake.
// Define LFSR_MISR_EN to add data_in/misr_mode signature compression ports.
module lfsr_prng
    import lfsr_pkg::*;
#(
    parameter int unsigned         WIDTH        = 6,
    parameter logic [WIDTH-1:0]    TAPS         = WIDTH'(DEF_TAPS_6),
    parameter logic [WIDTH-1:0]    DEFAULT_SEED = WIDTH'(DEF_SEED_6),
    parameter int unsigned         BURST_W      = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               seed_load,
    input  logic [WIDTH-1:0]   seed,
    input  logic               shift_en,
    input  logic               seed_bit,
    input  logic               run,
    input  logic               step,
    input  logic               burst_start,
    input  logic [BURST_W-1:0] burst_len,
`ifdef LFSR_MISR_EN
    input  logic [WIDTH-1:0]   data_in,
    input  logic               misr_mode,
`endif
    output logic               busy,
    output logic               done,
    input  logic               fetch,
    output logic               write,
    output logic [WIDTH-1:0]   out,
    output logic               lockup
);

    fsm_state_e         fsm_q, fsm_d;
    logic [BURST_W-1:0] cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               write_q;
    logic [WIDTH-1:0]   out_q;
    logic               adv_en_c;
    logic [WIDTH-1:0]   state_c;

    lfsr_core #(
        .WIDTH        (WIDTH),
        .TAPS         (TAPS),
        .DEFAULT_SEED (DEFAULT_SEED)
    ) u_core (
        .clock       (clock),
        .reset_n     (reset_n),
        .seed_load_i (seed_load),
        .seed_i      (seed),
        .shift_en_i  (shift_en),
        .seed_bit_i  (seed_bit),
        .adv_en_i    (adv_en_c),
`ifdef LFSR_MISR_EN
        .data_in_i   (data_in),
        .misr_mode_i (misr_mode),
`endif
        .state_o     (state_c),
        .lockup_o    (lockup)
    );

    // Run level advances on every sampled edge, including the IDLE->RUN edge.
    always_comb begin
        fsm_d    = fsm_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        adv_en_c = 1'b0;
        if (seed_load || shift_en) begin
            fsm_d  = ST_IDLE;
            cnt_d  = '0;
            busy_d = 1'b0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (run) begin
                        fsm_d    = ST_RUN;
                        adv_en_c = 1'b1;
                    end else if (burst_start && (burst_len != '0)) begin
                        fsm_d  = ST_BURST;
                        cnt_d  = burst_len;
                        busy_d = 1'b1;
                    end else if (step) begin
                        adv_en_c = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (run) begin
                        adv_en_c = 1'b1;
                    end else begin
                        fsm_d = ST_IDLE;
                    end
                end
                ST_BURST: begin
                    adv_en_c = 1'b1;
                    if (cnt_q == BURST_W'(1)) begin
                        fsm_d  = ST_IDLE;
                        cnt_d  = '0;
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - BURST_W'(1);
                    end
                end
                default: begin
                    fsm_d  = ST_IDLE;
                    cnt_d  = '0;
                    busy_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q  <= ST_IDLE;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // Snapshot is the state held at the fetch edge, before that edge's update.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            write_q <= 1'b0;
            out_q   <= DEFAULT_SEED;
        end else begin
            write_q <= fetch;
            if (fetch) begin
                out_q <= state_c;
            end
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign write = write_q;
    assign out   = out_q;

endmodule

// File: tb/tb_lfsr_prng.sv
// Directed self-checking bench for lfsr_prng (6-bit, taps x^6+x^5+1, seed 01).
// MISR vector is included only when LFSR_MISR_EN is defined.
module tb_lfsr_prng;

    logic       clock;
    logic       reset_n;
    logic       seed_load;
    logic [5:0] seed;
    logic       shift_en;
    logic       seed_bit;
    logic       run;
    logic       step;
    logic       burst_start;
    logic [7:0] burst_len;
`ifdef LFSR_MISR_EN
    logic [5:0] data_in;
    logic       misr_mode;
`endif
    logic       busy;
    logic       done;
    logic       fetch;
    logic       write;
    logic [5:0] out;
    logic       lockup;

    int n_checks = 0;
    int n_errors = 0;

    lfsr_prng #(
        .WIDTH        (6),
        .TAPS         (6'b110000),
        .DEFAULT_SEED (6'h01),
        .BURST_W      (8)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .seed_load   (seed_load),
        .seed        (seed),
        .shift_en    (shift_en),
        .seed_bit    (seed_bit),
        .run         (run),
        .step        (step),
        .burst_start (burst_start),
        .burst_len   (burst_len),
`ifdef LFSR_MISR_EN
        .data_in     (data_in),
        .misr_mode   (misr_mode),
`endif
        .busy        (busy),
        .done        (done),
        .fetch       (fetch),
        .write       (write),
        .out         (out),
        .lockup      (lockup)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fetch_check(input string tag, input logic [5:0] exp);
        fetch = 1'b1;
        @(negedge clock);
        fetch = 1'b0;
        chk({tag, "_write"}, 32'(write), 32'd1);
        chk(tag, 32'(out), 32'(exp));
    endtask

    task automatic load_seed(input logic [5:0] v);
        seed_load = 1'b1;
        seed      = v;
        @(negedge clock);
        seed_load = 1'b0;
    endtask

    logic [5:0] step_exp [6];
    int         bad;
    int         busy_cnt;
    int         done_cnt;

    initial begin
        step_exp = '{6'h02, 6'h04, 6'h08, 6'h10, 6'h21, 6'h03};
        reset_n = 1'b0; seed_load = 1'b0; seed = '0; shift_en = 1'b0; seed_bit = 1'b0;
        run = 1'b0; step = 1'b0; burst_start = 1'b0; burst_len = '0; fetch = 1'b0;
`ifdef LFSR_MISR_EN
        data_in = '0; misr_mode = 1'b0;
`endif
        #12;
        chk("rst_out",    32'(out),    32'h01);
        chk("rst_write",  32'(write),  32'd0);
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_done",   32'(done),   32'd0);
        chk("rst_lockup", 32'(lockup), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Single steps from the reset seed
        for (int i = 0; i < 6; i++) begin
            step = 1'b1;
            @(negedge clock);
            step = 1'b0;
            fetch_check($sformatf("step%0d", i), step_exp[i]);
        end

        // Free run for a full period
        load_seed(6'h01);
        run = 1'b1; fetch = 1'b1; bad = 0;
        for (int i = 0; i < 63; i++) begin
            @(negedge clock);
            if (i == 0) chk("run_first", 32'(out), 32'h01);
            else if (i == 1) chk("run_second", 32'(out), 32'h02);
            else if (out == 6'h01 || out == 6'h00) bad++;
        end
        run = 1'b0; fetch = 1'b0;
        @(negedge clock);
        chk("run_period", 32'(bad), 32'd0);
        fetch_check("run_wrap", 6'h01);

        // Parallel load, zero guard by load and by serial shift
        load_seed(6'h15);
        chk("load_nolock", 32'(lockup), 32'd0);
        fetch_check("load_val", 6'h15);
        load_seed(6'h00);
        chk("zload_lock", 32'(lockup), 32'd1);
        @(negedge clock);
        chk("zload_lock_end", 32'(lockup), 32'd0);
        fetch_check("zload_val", 6'h01);
        shift_en = 1'b1; seed_bit = 1'b0; bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (i < 5 && lockup) bad++;
        end
        shift_en = 1'b0;
        chk("zshift_early", 32'(bad), 32'd0);
        chk("zshift_lock", 32'(lockup), 32'd1);
        @(negedge clock);
        chk("zshift_lock_end", 32'(lockup), 32'd0);
        fetch_check("zshift_val", 6'h01);
        shift_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            seed_bit = (i % 2 == 0);
            @(negedge clock);
        end
        shift_en = 1'b0;
        fetch_check("shift_val", 6'h2A);

        // Burst of 5 from 01
        load_seed(6'h01);
        burst_start = 1'b1; burst_len = 8'd5;
        @(negedge clock);
        burst_start = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (i == 5) chk("burst_done_at_end", 32'(done), 32'd1);
            @(negedge clock);
        end
        chk("burst_busy_cycles", 32'(busy_cnt), 32'd5);
        chk("burst_done_cycles", 32'(done_cnt), 32'd1);
        fetch_check("burst_val", 6'h21);

        // Burst aborted by a seed load on its third cycle
        load_seed(6'h01);
        burst_start = 1'b1; burst_len = 8'd5;
        @(negedge clock);
        burst_start = 1'b0;
        @(negedge clock);
        seed_load = 1'b1; seed = 6'h0A;
        @(negedge clock);
        seed_load = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (done || busy) done_cnt++;
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        fetch_check("abort_val", 6'h0A);

        // Zero-length burst is a no-op
        burst_start = 1'b1; burst_len = 8'd0;
        @(negedge clock);
        burst_start = 1'b0;
        chk("blen0_busy", 32'(busy), 32'd0);
        @(negedge clock);
        chk("blen0_done", 32'(done), 32'd0);
        fetch_check("blen0_val", 6'h0A);

        // Step ignored while in RUN (including the RUN->IDLE edge)
        load_seed(6'h01);
        run = 1'b1; step = 1'b1;
        @(negedge clock);
        @(negedge clock);
        run = 1'b0;
        @(negedge clock);
        step = 1'b0;
        fetch_check("step_in_run", 6'h04);

        // Asynchronous reset mid-RUN
        load_seed(6'h01);
        run = 1'b1; fetch = 1'b1;
        repeat (3) @(negedge clock);
        chk("pre_rst_out", 32'(out), 32'h04);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_out",   32'(out),   32'h01);
        chk("arst_write", 32'(write), 32'd0);
        chk("arst_busy",  32'(busy),  32'd0);
        @(negedge clock);
        chk("rst_fetch_ignored", 32'(write), 32'd0);
        run = 1'b0; fetch = 1'b0;
        reset_n = 1'b1;
        fetch_check("arst_state", 6'h01);

        // Asynchronous reset mid-burst: no done afterwards
        burst_start = 1'b1; burst_len = 8'd10;
        @(negedge clock);
        burst_start = 1'b0;
        @(negedge clock);
        chk("rburst_busy", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1 chk("rburst_busy_rst", 32'(busy), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (done || busy) done_cnt++;
        end
        chk("rburst_no_done", 32'(done_cnt), 32'd0);

`ifdef LFSR_MISR_EN
        // Signature compression step
        load_seed(6'h01);
        misr_mode = 1'b1; data_in = 6'h3F; step = 1'b1;
        @(negedge clock);
        step = 1'b0; misr_mode = 1'b0;
        fetch_check("misr_val", 6'h3D);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
